// File: rtl/hubris_io_pkg.sv
// Shared constants for the Hubris IO drain path: UART FSM state encoding,
// frame geometry and the idle line level.
package hubris_io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int   UART_DATA_BITS = 8;
   localparam logic TX_IDLE        = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable down-counter timing one UART bit (or stop period); done pulses
// for exactly one cycle on the last cycle of each loaded period.
module uart_bit_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;
   logic             armed;

   // NOTE: sequential state is updated with <= only, so every flop samples
   // the pre-edge values of its neighbours regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         armed <= 1'b0;
      end else if (load) begin
         count <= load_value;
         armed <= 1'b1;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end else begin
         armed <= 1'b0;
      end
   end

   // armed keeps done from sticking high while the counter idles at zero
   assign done = armed && (count == '0);

endmodule

// File: rtl/io_uart_tx_drain.sv
// Drains the unified memory's output IO buffer one byte at a time and
// serialises each byte as an 8N1/8N2 UART frame on tx.
module io_uart_tx_drain
   import hubris_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] io_buffer_size_avai,
   input  logic [7:0]  io_output_data,
   output logic        io_output_en,
   output logic        tx,
   output logic        busy,
   output logic [31:0] byte_count
);

   localparam int TIMER_WIDTH = ($clog2(CLKS_PER_BIT * STOP_BITS) < 1) ? 1
                                : $clog2(CLKS_PER_BIT * STOP_BITS);
   localparam logic [TIMER_WIDTH-1:0] BIT_LOAD  = TIMER_WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [TIMER_WIDTH-1:0] STOP_LOAD = TIMER_WIDTH'(CLKS_PER_BIT * STOP_BITS - 1);

   generate
      if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
         $error("io_uart_tx_drain: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
      end
   endgenerate

   tx_state_e                 state;
   logic [UART_DATA_BITS-1:0] shift_reg;
   logic [2:0]                bit_idx;
   logic                      last_bit;
   logic                      timer_load;
   logic                      timer_done;
   logic [TIMER_WIDTH-1:0]    timer_value;

   assign io_output_en = (state == IDLE) && enable && (io_buffer_size_avai != '0) && !reset;
   assign last_bit     = (bit_idx == 3'(UART_DATA_BITS - 1));

   // NOTE: every always_comb output gets a value on every path (defaults
   // first) so no latch can be inferred.
   always_comb begin
      timer_load  = io_output_en || ((state != IDLE) && timer_done);
      timer_value = BIT_LOAD;
      if (state == DATA && last_bit) timer_value = STOP_LOAD;
   end

   uart_bit_timer #(
      .WIDTH(TIMER_WIDTH)
   ) u_bit_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (timer_load),
      .load_value(timer_value),
      .done      (timer_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         tx         <= TX_IDLE;
         busy       <= 1'b0;
         byte_count <= '0;
         shift_reg  <= '0;
         bit_idx    <= '0;
      end else begin
         case (state)
            IDLE: if (io_output_en) begin
               shift_reg  <= io_output_data;
               byte_count <= byte_count + 32'd1;
               tx         <= 1'b0;
               busy       <= 1'b1;
               state      <= START;
            end
            START: if (timer_done) begin
               tx        <= shift_reg[0];
               shift_reg <= shift_reg >> 1;
               bit_idx   <= '0;
               state     <= DATA;
            end
            DATA: if (timer_done) begin
               if (last_bit) begin
                  tx    <= TX_IDLE;
                  state <= STOP;
               end else begin
                  tx        <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  bit_idx   <= bit_idx + 3'd1;
               end
            end
            STOP: if (timer_done) begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_uart_tx_drain.sv
// Scoreboard bench: stimulus queues expected bytes, per-DUT monitors decode
// every popped frame from tx and compare. DUT0 is 8N1, DUT1 is 8N2.
module tb_io_uart_tx_drain;

   localparam int N = 4;

   typedef logic [7:0] u8;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable0, enable1;
   logic [31:0] avai0, avai1;
   logic [7:0]  data0, data1;
   logic        en0, en1, tx0, tx1, busy0, busy1;
   logic [31:0] bc0, bc1;

   u8  buf_q[2][$];
   u8  exp_q[2][$];
   int pop_cyc[2][$];
   int cycle    = 0;
   int n_pass   = 0;
   int n_checks = 0;

   io_uart_tx_drain #(.CLKS_PER_BIT(N), .STOP_BITS(1)) dut0 (
      .clk(clk), .reset(reset), .enable(enable0), .io_buffer_size_avai(avai0),
      .io_output_data(data0), .io_output_en(en0), .tx(tx0), .busy(busy0), .byte_count(bc0));

   io_uart_tx_drain #(.CLKS_PER_BIT(N), .STOP_BITS(2)) dut1 (
      .clk(clk), .reset(reset), .enable(enable1), .io_buffer_size_avai(avai1),
      .io_output_data(data1), .io_output_en(en1), .tx(tx1), .busy(busy1), .byte_count(bc1));

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic load(input int d, input u8 b);
      buf_q[d].push_back(b);
      exp_q[d].push_back(b);
   endtask

   // Memory output buffer model: first-word fall-through, pops on en at posedge
   initial begin
      bit will0, will1;
      avai0 = '0; data0 = '0; avai1 = '0; data1 = '0;
      forever begin
         @(negedge clk);
         will0 = en0;
         will1 = en1;
         @(posedge clk);
         #1;
         if (will0 && buf_q[0].size() != 0) void'(buf_q[0].pop_front());
         if (will1 && buf_q[1].size() != 0) void'(buf_q[1].pop_front());
         avai0 = 32'(buf_q[0].size());
         data0 = (buf_q[0].size() != 0) ? buf_q[0][0] : 8'h00;
         avai1 = 32'(buf_q[1].size());
         data1 = (buf_q[1].size() != 0) ? buf_q[1][0] : 8'h00;
      end
   end

   // Frame monitor: on each pop, sample the whole frame and compare it
   task automatic monitor(input int d);
      int          len;
      logic [43:0] smp;
      u8           want, got;
      bit          has_exp, aborted, busy_ok, start_ok, stop_ok, stable_ok;
      len = (d == 0) ? 9 * N + N : 9 * N + 2 * N;
      forever begin
         @(negedge clk);
         if (((d == 0) ? en0 : en1) === 1'b1) begin
            pop_cyc[d].push_back(cycle);
            check("busy_low_at_pop", 32'((d == 0) ? busy0 : busy1), 32'd0);
            has_exp = (exp_q[d].size() != 0);
            want    = has_exp ? exp_q[d].pop_front() : 8'h00;
            if (!has_exp) check("unexpected_pop", 32'd1, 32'd0);
            aborted = 1'b0; busy_ok = 1'b1; smp = '0;
            for (int k = 0; k < len; k++) begin
               @(negedge clk);
               if (reset) begin
                  aborted = 1'b1;
                  break;
               end
               smp[k] = (d == 0) ? tx0 : tx1;
               if (((d == 0) ? busy0 : busy1) !== 1'b1) busy_ok = 1'b0;
            end
            if (!aborted && has_exp) begin
               start_ok = 1'b1; stop_ok = 1'b1; stable_ok = 1'b1; got = '0;
               for (int k = 0; k < N; k++) if (smp[k] !== 1'b0) start_ok = 1'b0;
               for (int i = 0; i < 8; i++) begin
                  got[i] = smp[N + N * i];
                  for (int j = 1; j < N; j++) if (smp[N + N * i + j] !== got[i]) stable_ok = 1'b0;
               end
               for (int k = 9 * N; k < len; k++) if (smp[k] !== 1'b1) stop_ok = 1'b0;
               check("frame_byte", 32'(got), 32'(want));
               check("frame_start_low", 32'(start_ok), 32'd1);
               check("frame_bits_stable", 32'(stable_ok), 32'd1);
               check("frame_stop_high", 32'(stop_ok), 32'd1);
               check("frame_busy_high", 32'(busy_ok), 32'd1);
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   initial begin
      int cnt, txlow, base;
      reset = 1'b1; enable0 = 1'b1; enable1 = 1'b0;

      // Reset hold with three bytes waiting
      buf_q[0].push_back(8'hAA); buf_q[0].push_back(8'hBB); buf_q[0].push_back(8'hCC);
      tick(1);
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (en0 !== 1'b0) cnt++;
      end
      check("reset_no_pop", 32'(cnt), 32'd0);
      check("reset_avai_seen", avai0, 32'd3);
      check("reset_tx", 32'(tx0), 32'd1);
      check("reset_busy", 32'(busy0), 32'd0);
      check("reset_byte_count", bc0, 32'd0);
      buf_q[0].delete();
      tick(2);
      reset = 1'b0;
      tick(2);

      // Single byte 0x41
      load(0, 8'h41);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (en0 === 1'b1) cnt++;
      end
      check("single_pop_once", 32'(cnt), 32'd1);
      check("single_byte_count", bc0, 32'd1);
      check("single_idle_tx", 32'(tx0), 32'd1);

      // Stream "Hi\n"
      base = pop_cyc[0].size();
      load(0, 8'h48); load(0, 8'h69); load(0, 8'h0A);
      tick(3 * 41 + 10);
      check("stream_pops", 32'(pop_cyc[0].size() - base), 32'd3);
      check("stream_gap_1", 32'(pop_cyc[0][base + 1] - pop_cyc[0][base]), 32'd41);
      check("stream_gap_2", 32'(pop_cyc[0][base + 2] - pop_cyc[0][base + 1]), 32'd41);
      check("stream_byte_count", bc0, 32'd4);
      check("stream_buffer_empty", avai0, 32'd0);

      // enable low with five buffered bytes
      enable0 = 1'b0;
      load(0, 8'h00); load(0, 8'hFF); load(0, 8'h55); load(0, 8'hA5); load(0, 8'h3C);
      base = pop_cyc[0].size();
      cnt = 0; txlow = 0;
      repeat (100) begin
         @(negedge clk);
         if (en0 !== 1'b0) cnt++;
         if (tx0 !== 1'b1) txlow++;
      end
      check("disabled_no_pop", 32'(cnt), 32'd0);
      check("disabled_tx_high", 32'(txlow), 32'd0);
      @(posedge clk); #2;
      enable0 = 1'b1;
      #1;
      check("enable_pops_same_cycle", 32'(en0), 32'd1);
      tick(16);
      enable0 = 1'b0;
      tick(60);
      check("drop_enable_one_pop", 32'(pop_cyc[0].size() - base), 32'd1);
      check("drop_enable_byte_count", bc0, 32'd5);
      check("drop_enable_buffer", avai0, 32'd4);

      // Reset during DATA bit 3 of byte 0xFF
      enable0 = 1'b1;
      tick(1);
      tick(17);
      reset = 1'b1;
      @(negedge clk);
      check("reset_forces_en_low", 32'(en0), 32'd0);
      @(negedge clk);
      check("midreset_tx", 32'(tx0), 32'd1);
      check("midreset_busy", 32'(busy0), 32'd0);
      check("midreset_byte_count", bc0, 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      check("release_pops_first_cycle", 32'(en0), 32'd1);
      tick(5);
      enable0 = 1'b0;
      tick(50);
      check("after_reset_byte_count", bc0, 32'd1);
      check("after_reset_buffer", avai0, 32'd2);
      check("after_reset_leftover_exp", 32'(exp_q[0].size()), 32'd2);
      buf_q[0].delete();
      exp_q[0].delete();

      // Two stop bits, two bytes
      base = pop_cyc[1].size();
      load(1, 8'h96); load(1, 8'hC3);
      enable1 = 1'b1;
      tick(2 * 45 + 10);
      check("stop2_pops", 32'(pop_cyc[1].size() - base), 32'd2);
      check("stop2_gap", 32'(pop_cyc[1][base + 1] - pop_cyc[1][base]), 32'd45);
      check("stop2_byte_count", bc1, 32'd2);
      check("stop2_scoreboard_drained", 32'(exp_q[1].size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/io_uart_tx_drain.md
Name: io_uart_tx_drain

Overview:
- Downstream consumer of the unified memory's external output IO buffer.
- Pops bytes the Hubris core writes to the memory-mapped output port and serialises each one as an 8N1 (or 8N2) UART frame on a single tx line.
- Replaces the simulation-only character print on FPGA builds.
- Sits beside the unified memory instance at top level and connects directly to its io_output_en, io_output_data and io_buffer_size_avai ports.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  when low, no new byte is popped; the frame in progress completes
- io_buffer_size_avai  input  32  bytes currently held in the memory output buffer
- io_output_data  input  8  head byte of the buffer (first-word fall-through), valid when io_buffer_size_avai != 0
- io_output_en  output  1  pop strobe; the buffer advances at a posedge where this is high and io_buffer_size_avai != 0
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a frame is being shifted (START, DATA or STOP)
- byte_count  output  32  total bytes popped since reset, wraps modulo 2^32

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high. While reset is high: state=IDLE, tx=1, busy=0, byte_count=0, bit counter and baud counter = 0. io_output_en is forced to 0 while reset is high.
- io_output_en is combinational: (state==IDLE) && enable && (io_buffer_size_avai != 0) && !reset.
- IDLE state:
  - If io_output_en is high at a posedge: latch io_output_data into the shift register, increment byte_count, and go to START. The handshake pops exactly one byte.
  - Otherwise stay in IDLE with tx=1.
- START state: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA state:
  - 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - The bit index runs 0..7; after bit 7 completes, go to STOP.
- STOP state: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - Width is $clog2(CLKS_PER_BIT*STOP_BITS), with a minimum of 1.
- tx is registered and glitch-free. It changes only on state entry or bit boundaries.
- Timing:
  - The first START cycle of tx is the cycle after the pop.
  - busy is high from the cycle after the pop until the last STOP cycle inclusive.
- Streaming:
  - IDLE is always occupied for at least one cycle between frames.
  - Pop-to-pop spacing is exactly 1 + (9+STOP_BITS)*CLKS_PER_BIT cycles.
- enable deasserted mid-frame: the frame finishes normally and no further pop occurs.
- Buffer becoming empty: no pop; tx stays high. The block never pops while io_buffer_size_avai == 0.
- Reset mid-frame: the next cycle shows tx=1, busy=0, state=IDLE. The partially sent byte is lost, because it was already popped.
- Illegal parameter values are rejected by an elaboration-time check via $error in a generate block.

Decomposition:
- Shared package hubris_io_pkg holds:
  - State encoding localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - UART_DATA_BITS=8.
  - Idle-line level constant TX_IDLE=1'b1.
- One natural sub-module, uart_bit_timer:
  - Parameterised down-counter with a load input and a one-cycle done pulse.
  - Instantiated once; reloaded per bit and per stop period.

Test Plan:
- Reset: hold reset 5 cycles with io_buffer_size_avai=3 -> io_output_en=0 throughout, tx=1, busy=0, byte_count=0.
- Single byte (CLKS_PER_BIT=4, STOP_BITS=1), io_buffer_size_avai=1 with data 0x41:
  - io_output_en is high for exactly 1 cycle.
  - tx is then 0 for 4 cycles, bits 1,0,0,0,0,0,1,0 for 4 cycles each, then 1 for 4 cycles.
  - byte_count=1 and busy is high for 40 cycles.
- Stream "Hi\n" (0x48, 0x69, 0x0A) from a model buffer:
  - Pops occur 41 cycles apart and the decoded bytes match in order.
  - byte_count=3 and the buffer reaches 0.
- enable=0 with io_buffer_size_avai=5 for 100 cycles:
  - No pop and tx=1.
  - Raising enable pops on the same cycle.
  - Dropping enable during DATA still completes the frame, with no second pop.
- Reset asserted during DATA bit 3:
  - The next cycle shows tx=1, busy=0, byte_count=0.
  - After release, the next buffered byte pops on the first cycle.
- STOP_BITS=2, CLKS_PER_BIT=4, two bytes: the stop high lasts 8 cycles and pop spacing is 45 cycles.
